apu_int_div_responder: RTL and testbench
========================================

APU_INT_DIV_RESPONDER -- requirements
Module: apu_int_div_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have parameter WOP, default 3, giving the opcode width.
REQ-003 SHALL have parameter TAG_WIDTH, default 4, giving the requester tag width.
REQ-004 SHALL have clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have apu_req_i  input  1  request valid.
REQ-007 SHALL have apu_gnt_o  output  1  request accepted.
REQ-008 SHALL have apu_op_i  input  WOP  opcode.
REQ-009 SHALL have apu_operand_a_i  input  WIDTH  dividend.
REQ-010 SHALL have apu_operand_b_i  input  WIDTH  divisor.
REQ-011 SHALL have apu_tag_i  input  TAG_WIDTH  requester ID, returned with the result.
REQ-012 SHALL have apu_rvalid_o  output  1  result valid.
REQ-013 SHALL have apu_rready_i  input  1  result consumed.
REQ-014 SHALL have apu_rdata_o  output  WIDTH  result.
REQ-015 SHALL have apu_rtag_o  output  TAG_WIDTH  tag of the result.
REQ-016 SHALL have busy_o  output  1  high whenever state != IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY, FIX and DONE.
REQ-018 apu_gnt_o SHALL equal apu_req_i AND (state==IDLE), combinationally; no request is accepted in any other state.
REQ-019 An accept (req&gnt at a clock edge) SHALL register op, |a|, |b|, the sign info and the tag.
REQ-020 Accept with b==0 SHALL go directly to DONE with rvalid on the next cycle:
  - DIV/DIVU: result = all-ones.
  - REM/REMU: result = a.
REQ-021 Accept with signed op, a==2^(WIDTH-1) and b==all-ones SHALL go directly to DONE:
  - DIV: result = a.
  - REM: result = 0.
REQ-022 Any other accept SHALL enter BUSY with a step counter = WIDTH-1.
REQ-023 Each BUSY cycle SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first.
REQ-024 BUSY SHALL exit to FIX after exactly WIDTH steps.
REQ-025 FIX SHALL apply the sign correction for one cycle:
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - FIX then moves to DONE.
REQ-026 Normal latency SHALL be exactly WIDTH+2 cycles from the accept edge to the first cycle with apu_rvalid_o high (34 for WIDTH=32).
REQ-027 In DONE, apu_rvalid_o SHALL be 1, and apu_rdata_o and apu_rtag_o SHALL be held stable until apu_rvalid_o&apu_rready_i at an edge; the FSM then returns to IDLE.
REQ-028 A new request SHALL be granted no earlier than the cycle after the result handshake.
REQ-029 Opcode encodings SHALL be 000 DIV, 001 DIVU, 010 REM, 011 REMU.
REQ-030 Reserved opcodes 1xx SHALL be accepted, go directly to DONE, and return result 0.
REQ-031 Outside DONE, apu_rdata_o and apu_rtag_o SHALL be driven to 0.

Reset
REQ-032 While rst_ni is low, the FSM SHALL be IDLE, all registers SHALL be 0, and apu_rvalid_o, busy_o, apu_rdata_o and apu_rtag_o SHALL be 0.
REQ-033 Reset asserted in BUSY, FIX or DONE SHALL abort the operation immediately with no result delivered.
REQ-034 After reset release, the first request SHALL be grantable in the first cycle.

Structure
REQ-035 Opcode constants (APU_INTDIV_DIV/DIVU/REM/REMU) and the state typedef SHALL live in apu_cluster_package, alongside WOP_INT_DIV and DSP_WIDTH.
REQ-036 WIDTH and WOP defaults SHALL match DSP_WIDTH and WOP_INT_DIV.
REQ-037 The block SHALL be a single flat module with no sub-module; the datapath is one WIDTH+1-bit subtractor plus quotient and remainder shift registers.

Verification
REQ-038 DIVU a=100, b=7, tag=3 -> gnt same cycle; rvalid exactly 34 cycles after accept; rdata=14; rtag=3.
REQ-039 DIV a=-100, b=7, then REM with the same operands -> results 0xFFFFFFF2 (-14) and 0xFFFFFFFE (-2).
REQ-040 DIV a=5, b=0, then REMU a=5, b=0 -> rvalid 1 cycle after accept; results 0xFFFFFFFF and 5.
REQ-041 DIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000 after 1 cycle; REM with the same operands -> result 0.
REQ-042 Hold rready low for 10 cycles in DONE while req is high -> rdata/rtag stable and gnt low throughout; after the handshake, gnt rises one cycle later.
REQ-043 Pull rst_ni low in the 10th BUSY cycle -> all outputs 0 asynchronously; after release, DIVU 9/3 returns 3 with no stale result.

Source files
------------

// File: rtl/apu_int_div_responder_pkg.sv
// Shared constants and types for the APU integer divide responder.
package apu_cluster_package;

  localparam int unsigned DSP_WIDTH   = 32;
  localparam int unsigned WOP_INT_DIV = 3;

  localparam logic [WOP_INT_DIV-1:0] APU_INTDIV_DIV  = 3'b000;
  localparam logic [WOP_INT_DIV-1:0] APU_INTDIV_DIVU = 3'b001;
  localparam logic [WOP_INT_DIV-1:0] APU_INTDIV_REM  = 3'b010;
  localparam logic [WOP_INT_DIV-1:0] APU_INTDIV_REMU = 3'b011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage : apu_cluster_package

// File: rtl/apu_int_div_responder.sv
// Iterative restoring divider behind an APU req/gnt + rvalid/rready handshake.
// One quotient bit per cycle MSB-first, then a single sign-fix cycle.
module apu_int_div_responder
  import apu_cluster_package::*;
#(
  parameter int unsigned WIDTH     = DSP_WIDTH,
  parameter int unsigned WOP       = WOP_INT_DIV,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 apu_req_i,
  output logic                 apu_gnt_o,
  input  logic [WOP-1:0]       apu_op_i,
  input  logic [WIDTH-1:0]     apu_operand_a_i,
  input  logic [WIDTH-1:0]     apu_operand_b_i,
  input  logic [TAG_WIDTH-1:0] apu_tag_i,
  output logic                 apu_rvalid_o,
  input  logic                 apu_rready_i,
  output logic [WIDTH-1:0]     apu_rdata_o,
  output logic [TAG_WIDTH-1:0] apu_rtag_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 op_rem_q, op_rem_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;

  // Request decode: bit0 selects unsigned, bit1 selects remainder, upper bits reserved
  logic             req_reserved, req_signed, req_rem, req_a_neg, req_b_neg;
  logic             req_div_zero, req_overflow;
  logic [WIDTH-1:0] req_abs_a, req_abs_b;

  assign req_reserved = |apu_op_i[WOP-1:2];
  assign req_signed   = ~apu_op_i[0];
  assign req_rem      = apu_op_i[1];
  assign req_a_neg    = req_signed & apu_operand_a_i[WIDTH-1];
  assign req_b_neg    = req_signed & apu_operand_b_i[WIDTH-1];
  assign req_abs_a    = req_a_neg ? -apu_operand_a_i : apu_operand_a_i;
  assign req_abs_b    = req_b_neg ? -apu_operand_b_i : apu_operand_b_i;
  assign req_div_zero = (apu_operand_b_i == '0);
  assign req_overflow = req_signed & (apu_operand_a_i == MIN_VAL) & (&apu_operand_b_i);

  // Shared WIDTH+1-bit subtractor; its MSB is the borrow of the trial subtraction
  logic [WIDTH:0] partial, diff;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    res_d    = res_q;
    tag_d    = tag_q;
    op_rem_d = op_rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    partial  = {rem_q, quo_q[WIDTH-1]};
    diff     = partial - {1'b0, div_q};

    unique case (state_q)
      DIV_IDLE: begin
        if (apu_req_i) begin
          tag_d    = apu_tag_i;
          op_rem_d = req_rem;
          neg_a_d  = req_a_neg;
          neg_b_d  = req_b_neg;
          quo_d    = req_abs_a;
          rem_d    = '0;
          div_d    = req_abs_b;
          cnt_d    = CNT_W'(WIDTH - 1);
          if (req_reserved) begin
            res_d   = '0;
            state_d = DIV_DONE;
          end else if (req_div_zero) begin
            res_d   = req_rem ? apu_operand_a_i : '1;
            state_d = DIV_DONE;
          end else if (req_overflow) begin
            res_d   = req_rem ? '0 : apu_operand_a_i;
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_d = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_FIX: begin
        if (op_rem_q) begin
          res_d = neg_a_q ? -rem_q : rem_q;
        end else begin
          res_d = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
        end
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (apu_rready_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      res_q    <= '0;
      tag_q    <= '0;
      op_rem_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
      op_rem_q <= op_rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
    end
  end

  assign apu_gnt_o    = apu_req_i & (state_q == DIV_IDLE);
  assign apu_rvalid_o = (state_q == DIV_DONE);
  assign busy_o       = (state_q != DIV_IDLE);
  assign apu_rdata_o  = (state_q == DIV_DONE) ? res_q : '0;
  assign apu_rtag_o   = (state_q == DIV_DONE) ? tag_q : '0;

endmodule : apu_int_div_responder

// File: tb/tb_apu_int_div_responder.sv
// Self-checking bench for apu_int_div_responder against an arithmetic reference model.
module tb_apu_int_div_responder;
  import apu_cluster_package::*;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  tag;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rtag;
  logic        busy;

  int errors;
  int checks;

  apu_int_div_responder dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .apu_req_i      (req),
    .apu_gnt_o      (gnt),
    .apu_op_i       (op),
    .apu_operand_a_i(a),
    .apu_operand_b_i(b),
    .apu_tag_i      (tag),
    .apu_rvalid_o   (rvalid),
    .apu_rready_i   (rready),
    .apu_rdata_o    (rdata),
    .apu_rtag_o     (rtag),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    if (o[2]) return 32'h0;
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o[1:0])
      2'b00:   return 32'(sx / sy);
      2'b01:   return 32'(ux / uy);
      2'b10:   return 32'(sx % sy);
      default: return 32'(ux % uy);
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o[2] || y == 32'h0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drives one transaction starting at a negedge; returns what was observed, ends at a negedge
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t, input int rdelay,
                        output logic [31:0] got_data, output logic [3:0] got_tag,
                        output int lat, output logic gnt_now, output logic got_valid);
    int n;
    req = 1'b1; op = o; a = x; b = y; tag = t; rready = 1'b0;
    #1;
    gnt_now = gnt;
    n = 0;
    while (!gnt && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; op = 3'h0; a = 32'h0; b = 32'h0; tag = 4'h0;
    lat = 1;
    #1;
    while (!rvalid && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    got_valid = rvalid;
    got_data  = rdata;
    got_tag   = rtag;
    repeat (rdelay) @(negedge clk);
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; op = 3'h0; a = 32'h0; b = 32'h0; tag = 4'h0; rready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rvalid, busy, rdata, rtag} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid=%b busy=%b rdata=%h rtag=%h, want all 0",
               rvalid, busy, rdata, rtag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] d; logic [3:0] t; int lat; logic g, v;
    // DIVU 100/7 with tag 3, first request after reset release
    run_op(APU_INTDIV_DIVU, 32'd100, 32'd7, 4'd3, 0, d, t, lat, g, v);
    checks++;
    if (g !== 1'b1 || v !== 1'b1) begin
      errors++; $display("FAIL divu_handshake: gnt=%b rvalid=%b, want 1 1", g, v);
    end
    checks++;
    if (lat !== 34) begin
      errors++; $display("FAIL divu_latency: got %0d, want 34", lat);
    end
    checks++;
    if (d !== 32'd14 || t !== 4'd3) begin
      errors++; $display("FAIL divu_result: got %h tag %h, want 0000000e tag 3", d, t);
    end
    run_op(APU_INTDIV_DIV, 32'hFFFF_FF9C, 32'd7, 4'd5, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'hFFFF_FFF2 || lat !== 34) begin
      errors++; $display("FAIL div_neg: got %h lat %0d, want fffffff2 lat 34", d, lat);
    end
    run_op(APU_INTDIV_REM, 32'hFFFF_FF9C, 32'd7, 4'd6, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'hFFFF_FFFE || t !== 4'd6) begin
      errors++; $display("FAIL rem_neg: got %h tag %h, want fffffffe tag 6", d, t);
    end
    run_op(APU_INTDIV_DIV, 32'd5, 32'd0, 4'd7, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'hFFFF_FFFF || lat !== 1) begin
      errors++; $display("FAIL div_by_zero: got %h lat %0d, want ffffffff lat 1", d, lat);
    end
    run_op(APU_INTDIV_REMU, 32'd5, 32'd0, 4'd8, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'd5 || lat !== 1) begin
      errors++; $display("FAIL remu_by_zero: got %h lat %0d, want 00000005 lat 1", d, lat);
    end
    run_op(APU_INTDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'h8000_0000 || lat !== 1) begin
      errors++; $display("FAIL div_overflow: got %h lat %0d, want 80000000 lat 1", d, lat);
    end
    run_op(APU_INTDIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'h0 || lat !== 1) begin
      errors++; $display("FAIL rem_overflow: got %h lat %0d, want 00000000 lat 1", d, lat);
    end
    run_op(3'b110, 32'd77, 32'd3, 4'd11, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'h0 || lat !== 1 || t !== 4'd11) begin
      errors++; $display("FAIL reserved_op: got %h lat %0d tag %h, want 0 lat 1 tag b", d, lat, t);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    req = 1'b1; op = APU_INTDIV_DIVU; a = 32'd1000; b = 32'd9; tag = 4'hC; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op = APU_INTDIV_DIV; a = 32'd50; b = 32'd5; tag = 4'h2;
    lat = 1;
    #1;
    while (!rvalid && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL bp_rvalid: got rvalid=%b after %0d cycles, want 1", rvalid, lat);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rdata !== 32'd111 || rtag !== 4'hC || gnt !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdata=%h rtag=%h gnt=%b, want 0000006f c 0", i, rdata, rtag, gnt);
      end
      @(negedge clk); #1;
    end
    rready = 1'b1;
    #1;
    checks++;
    if (gnt !== 1'b0) begin
      errors++; $display("FAIL bp_gnt_at_handshake: got %b, want 0", gnt);
    end
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    #1;
    checks++;
    if (gnt !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL bp_gnt_after: gnt=%b rvalid=%b rdata=%h, want 1 0 0", gnt, rvalid, rdata);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [3:0] t; int lat; logic g, v;
    req = 1'b1; op = APU_INTDIV_DIVU; a = 32'hDEAD_BEEF; b = 32'd13; tag = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h0 || rtag !== 4'h0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b rvalid=%b rdata=%h rtag=%h, want 1 0 0 0", busy, rvalid, rdata, rtag);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, busy, rdata, rtag} !== 38'h0) begin
      errors++;
      $display("FAIL abort_async: rvalid=%b busy=%b rdata=%h rtag=%h, want all 0", rvalid, busy, rdata, rtag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_stale: rvalid=%b busy=%b, want 0 0", rvalid, busy);
    end
    @(negedge clk);
    run_op(APU_INTDIV_DIVU, 32'd9, 32'd3, 4'd4, 0, d, t, lat, g, v);
    checks++;
    if (d !== 32'd3 || t !== 4'd4 || lat !== 34 || g !== 1'b1) begin
      errors++; $display("FAIL abort_recover: got %h tag %h lat %0d gnt %b, want 3 4 34 1", d, t, lat, g);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, x, y, exp_d; logic [3:0] t, tg; logic [2:0] o; int lat, exp_lat, mode;
    logic g, v;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      y = $urandom;
      tg = 4'($urandom_range(0, 15));
      if (mode == 0) y = 32'h0;
      else if (mode == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (mode == 2) y = 32'($urandom_range(1, 20));
      else if (mode == 3) y = -32'($urandom_range(1, 20));
      exp_d = ref_result(o, x, y);
      exp_lat = ref_latency(o, x, y);
      run_op(o, x, y, tg, $urandom_range(0, 2), d, t, lat, g, v);
      checks++;
      if (d !== exp_d || t !== tg || lat !== exp_lat || g !== 1'b1 || v !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h tag %h lat %0d gnt %b, want %h tag %h lat %0d gnt 1",
                 i, o, x, y, d, t, lat, g, exp_d, tg, exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [3:0] t; int lat; logic g, v;
    for (int i = 0; i < 4; i++) begin
      run_op(APU_INTDIV_REMU, 32'd1000 + 32'(i), 32'd7, 4'(i), 0, d, t, lat, g, v);
      checks++;
      if (g !== 1'b1 || d !== ref_result(APU_INTDIV_REMU, 32'd1000 + 32'(i), 32'd7) || t !== 4'(i)) begin
        errors++; $display("FAIL b2b[%0d]: gnt=%b data=%h tag=%h", i, g, d, t);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    @(negedge clk);
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_apu_int_div_responder
